serial_frame_rx: RTL
====================

# serial_frame_rx

Serial frame receiver that sits directly downstream of the registered-input D flip-flop stage and consumes its 1-bit `q` output as a serial line. It detects a start bit, shifts in a `DATA_W`-bit word LSB first, optionally checks parity, checks the stop bit, and presents the word on a valid/ready output port. Framing, parity and overrun faults are reported as single-cycle pulses.

## Interface
- `DATA_W`, 8: data bits per frame, legal range 1–16.
- `PARITY_EN`, 1: 1 = a parity bit follows the data; 0 = no parity bit.
- `PARITY_ODD`, 0: 0 = even parity; 1 = odd parity. Ignored when `PARITY_EN`=0.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. 0 clears all state immediately.
- `din`  in  1  serial line, driven by the upstream flip-flop `q`. Idle level is 1.
- `bit_en`  in  1  sample strobe. `din` is sampled only in cycles where `bit_en`=1.
- `out_ready`  in  1  consumer accepts `dout` when it is 1 and `out_valid`=1.
- `dout`  out  DATA_W  received word.
- `out_valid`  out  1  `dout` holds an unconsumed word.
- `busy`  out  1  1 whenever the FSM is not in IDLE.
- `parity_err`  out  1  one-cycle pulse: the frame was dropped on parity mismatch.
- `frame_err`  out  1  one-cycle pulse: the frame was dropped because the stop bit was 0.
- `overrun`  out  1  one-cycle pulse: a good frame was dropped because the output was still occupied.

## Operation
- FSM states: IDLE, DATA, PARITY, STOP. Every transition requires `bit_en`=1. With `bit_en`=0 the FSM holds its state.
- IDLE: a sample of `din`=0 is the start bit. Clear the bit counter and the shift register, then go to DATA. A sample of `din`=1 stays in IDLE.
- DATA: shift `din` into the MSB end of the shift register, so bit 0 ends up in `dout[0]`. Increment the counter. After the `DATA_W`-th sample, go to PARITY if `PARITY_EN`=1, otherwise go to STOP.
- PARITY: capture the received bit. Go to STOP.
- Parity rule: XOR of the data bits XOR the parity bit must equal `PARITY_ODD`.
- STOP: sample the stop bit, then return to IDLE in every case. Resolve in this priority order:
  - If stop=0: pulse `frame_err` and drop the frame.
  - Else if parity is enabled and wrong: pulse `parity_err` and drop the frame.
  - Else if `out_valid`=1 and `out_ready`=0 in this cycle: pulse `overrun`, drop the frame, and leave `dout` unchanged.
  - Else: load `dout` and set `out_valid`=1.
- Output handshake: a transfer occurs in any cycle where `out_valid` and `out_ready` are both 1. After a transfer, `out_valid` clears next cycle unless a new word loads in the same cycle.
- `dout` holds its value while `out_valid`=0. It changes only on a load.
- The bit counter is `$clog2(DATA_W+1)` bits wide and never wraps mid-frame.

## Timing
- Reset (asynchronous, `reset`=0): FSM = IDLE, counter = 0, shift register = 0, `dout` = 0. `out_valid`, `busy`, `parity_err`, `frame_err`, `overrun` are all 0.
- Reset mid-frame aborts the frame silently, with no error pulse. It also discards any unconsumed `dout`.
- All outputs are registered.
- `busy` rises the cycle after the start-bit sample. It falls the cycle after the stop-bit sample.
- Load latency: `out_valid` and `dout` update on the clock edge that samples the stop bit. They are visible in the following cycle.
- Error pulses (`parity_err`, `frame_err`, `overrun`) are high for exactly one cycle, the cycle after the stop-bit sample.
- A frame occupies 2 + `DATA_W` + `PARITY_EN` strobes.
- Back-to-back frames are legal. The strobe after a stop bit may be the next start bit.
- With `bit_en` high every cycle, throughput is one word per 11 cycles at the defaults.
- Simultaneous load and consume (`out_valid`=1, `out_ready`=1, good stop sample): the new word loads, `out_valid` stays 1, and `overrun` stays 0.

## Test plan
All scenarios use the defaults (`DATA_W`=8, `PARITY_EN`=1, `PARITY_ODD`=0) and `bit_en`=1 every cycle. Serial sequences are listed in transmission order.

- Good frame: send 0xA5, i.e. start 0, data 1,0,1,0,0,1,0,1, parity 0, stop 1, with `out_ready`=0. Required: `dout`=0xA5 and `out_valid`=1 one cycle after the stop sample. `out_valid` holds until `out_ready`=1, then clears next cycle.
- Parity error: send 0x3C with parity bit 1. Required: `parity_err` pulses for one cycle, `out_valid` stays 0, `dout` is unchanged.
- Framing error: send 0x0F with correct parity 0 and stop 0. Required: `frame_err` pulses for one cycle, no load. An immediately following valid 0x81 frame is received correctly.
- Overrun: send 0x11, then 0x22, back-to-back, with `out_ready`=0 throughout. Required: `overrun` pulses at the end of the second frame, `dout` stays 0x11, `out_valid` stays 1. Repeat with `out_ready`=1 in the cycle of the second stop sample: `dout` becomes 0x22, `out_valid` stays 1, no `overrun`.
- Reset mid-frame: drive `reset`=0 asynchronously after the 4th data bit of 0xFF. Required: all outputs are 0 immediately, with no error pulse. After release, a fresh 0x5A frame is received correctly.
- Strobe gating: send 0xC3 with `bit_en` asserted every 3rd cycle and `din` toggling on non-strobe cycles. Required: `dout`=0xC3 is received.

Source files
------------

// File: rtl/serial_frame_rx.sv
// -----------------------------------------------------------------------------
// serial_frame_rx
//
// Serial frame receiver fed by a registered 1-bit line (idle level 1). A frame
// is: start bit (0), DATA_W data bits LSB first, an optional parity bit, and a
// stop bit (1). The line is only looked at in cycles where bit_en is high, so
// the sample rate is set entirely by the upstream strobe generator.
//
// A good frame is presented on a valid/ready port. Frames with a bad stop bit,
// a bad parity bit, or that arrive while the previous word is still waiting
// are dropped, and the cause is reported as a one-cycle pulse.
//
// Parameters
//   DATA_W      data bits per frame, 1..16
//   PARITY_EN   1 = a parity bit follows the data
//   PARITY_ODD  0 = even parity, 1 = odd parity (ignored when PARITY_EN = 0)
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   din         serial line, idle high
//   bit_en      sample strobe; din is ignored when low
//   out_ready   consumer ready; transfer when out_valid & out_ready
//   dout        received word (changes only when a new word loads)
//   out_valid   dout holds an unconsumed word
//   busy        receiver is inside a frame
//   parity_err  pulse: frame dropped on parity mismatch
//   frame_err   pulse: frame dropped because the stop bit was 0
//   overrun     pulse: good frame dropped because dout was still occupied
// -----------------------------------------------------------------------------
module serial_frame_rx #(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              din,
  input  logic              bit_en,
  input  logic              out_ready,
  output logic [DATA_W-1:0] dout,
  output logic              out_valid,
  output logic              busy,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
);

  // Counter is wide enough to hold DATA_W, so it can never wrap inside a frame.
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  localparam logic PAR_EN  = (PARITY_EN != 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   shift_q;
  logic                par_q;
  logic [DATA_W-1:0]   dout_q;
  logic                valid_q;
  logic                busy_q;
  logic                perr_q;
  logic                ferr_q;
  logic                ovr_q;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0]   shift_d;
  logic                parity_ok;
  logic                consume;
  logic                stop_blocked;

  // New bits enter at the MSB and move down, so after DATA_W samples the first
  // bit received sits in bit 0.
  generate
    if (DATA_W == 1) begin : g_shift_one
      assign shift_d = din;
    end else begin : g_shift_many
      assign shift_d = {din, shift_q[DATA_W-1:1]};
    end
  endgenerate

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    parity_ok = 1'b1;
    if (PAR_EN) begin
      parity_ok = ((^shift_q) ^ par_q) == PAR_ODD;
    end
  end

  assign consume      = valid_q & out_ready;
  // The held word is only in the way if it is not being taken this very cycle.
  assign stop_blocked = valid_q & ~out_ready;

  // ---------------------------------------------------------------------------
  // Receiver FSM with registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register sees the pre-edge value of every other register.
  // NOTE: all registers, including the data path (shift register, dout), are
  // cleared on reset; a mid-frame reset must discard the partial word and any
  // unconsumed output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      // Error outputs are single-cycle pulses.
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;

      // Handshake: a transfer empties the output unless a load below refills it.
      if (consume) begin
        valid_q <= 1'b0;
      end

      if (bit_en) begin
        unique case (state_q)
          ST_IDLE: begin
            if (!din) begin
              cnt_q   <= '0;
              shift_q <= '0;
              busy_q  <= 1'b1;
              state_q <= ST_DATA;
            end
          end

          ST_DATA: begin
            shift_q <= shift_d;
            cnt_q   <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
              state_q <= PAR_EN ? ST_PARITY : ST_STOP;
            end
          end

          ST_PARITY: begin
            par_q   <= din;
            state_q <= ST_STOP;
          end

          ST_STOP: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            // Fault priority: framing, then parity, then overrun.
            if (!din) begin
              ferr_q <= 1'b1;
            end else if (!parity_ok) begin
              perr_q <= 1'b1;
            end else if (stop_blocked) begin
              ovr_q <= 1'b1;
            end else begin
              dout_q  <= shift_q;
              valid_q <= 1'b1;
            end
          end

          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dout       = dout_q;
  assign out_valid  = valid_q;
  assign busy       = busy_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule
